uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_serializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional parity support is selected with UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and unregistered read data.
// Shared between the TX path and a future RX path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    wr_d;
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    rd_d;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_q - rd_q;
  assign full    = (level == PW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit back-end: byte FIFO feeding an 8N1 LSB-first serializer.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1 framing).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DIV        = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  state_e               state_q;
  state_e               state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BIT_W-1:0]     bit_q;
  logic [BIT_W-1:0]     bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 txd_q;
  logic                 txd_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
  logic                 parity_d;
`endif

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_rdata;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_bit;
  logic [CNT_W-1:0]     cnt_inc;

  assign tx_ready = !fifo_full && !areset;
  assign push     = tx_valid && tx_ready;
  assign txd      = txd_q;
  assign busy     = !areset && ((state_q != ST_IDLE) || !fifo_empty);
  assign bit_end  = (cnt_q == CNT_MAX);
  assign last_bit = (bit_q == BIT_MAX);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (push),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        txd_d = IDLE_LEVEL;
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          txd_d   = START_BIT;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            txd_d   = parity_q;
`else
            state_d = ST_STOP;
            txd_d   = STOP_BIT;
`endif
          end else begin
            // Next bit is already at shift_q[1] before the shift lands.
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = STOP_BIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
`else
        state_d = ST_IDLE;
        txd_d   = IDLE_LEVEL;
        cnt_d   = '0;
`endif
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          bit_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
            txd_d   = START_BIT;
          end else begin
            state_d = ST_IDLE;
            txd_d   = IDLE_LEVEL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = IDLE_LEVEL;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
    if (pop) begin
      shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      parity_d = even_parity(fifo_rdata);
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer (DIV=4, FIFO_DEPTH=16).
// Frames on txd are compared against a per-cycle waveform built from the byte.
module tb_uart_tx_serializer;

  localparam int DIV   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       aclk = 1'b0;
  logic       areset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_level;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  uart_tx_serializer #(
    .DIV        (DIV),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (16)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 aclk = ~aclk;

  // Line level for cycle k of a frame: start, 8 data LSB first,
  // optional even parity, stop.
  function automatic logic [FRAME-1:0] model_frame(input logic [7:0] b);
    logic [FRAME-1:0] f;
    int bi;
    for (int k = 0; k < FRAME; k++) begin
      bi = k / DIV;
      if (bi == 0)                 f[k] = 1'b0;
      else if (bi <= 8)            f[k] = b[bi-1];
      else if (bi == 9 && NB == 11) f[k] = ^b;
      else                         f[k] = 1'b1;
    end
    return f;
  endfunction

  task automatic wait_start(input string nm, output bit ok);
    int n = 0;
    while (txd !== 1'b0 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    ok = (txd === 1'b0);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: start bit timeout txd=%b", nm, txd);
    end
  endtask

  // Called on the first negedge after the start bit is driven;
  // returns on the negedge following the frame.
  task automatic capture_frame(input string nm, output logic [FRAME-1:0] got);
    logic [FRAME-1:0] ex;
    logic [7:0] b;
    for (int k = 0; k < FRAME; k++) begin
      got[k] = txd;
      @(negedge aclk);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected frame got=%h", nm, got);
    end else begin
      b  = exp_q.pop_front();
      ex = model_frame(b);
      if (got !== ex) begin
        bad++;
        $display("FAIL %s: byte %h frame got=%h exp=%h", nm, b, got, ex);
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge aclk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got=%b exp=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got=%0d exp=0", fifo_level); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%b exp=0", tx_ready); end
    areset = 1'b0;
    @(negedge aclk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got=%b exp=1", tx_ready); end
  endtask

  task automatic test_single;
    logic [FRAME-1:0] got;
    logic [FRAME-1:0] ex;
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge aclk);
    tx_valid = 1'b0;
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level1: got=%0d exp=1", fifo_level); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL single_pre_txd: got=%b exp=1", txd); end
    @(negedge aclk);
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL single_popped: got=%0d exp=0", fifo_level); end
    for (int k = 0; k < FRAME; k++) begin
      got[k] = txd;
      if (k == FRAME - 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_end: got=%b exp=1", busy); end
      end
      @(negedge aclk);
    end
    ex = model_frame(8'h55);
    total++; if (got !== ex) begin bad++; $display("FAIL single_frame: got=%h exp=%h", got, ex); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got=%b exp=0", busy); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL single_idle: got=%b exp=1", txd); end
  endtask

  task automatic test_back_to_back;
    logic [FRAME-1:0] got;
    bit ok;
    tx_valid = 1'b1; tx_data = 8'hA5; exp_q.push_back(8'hA5);
    @(negedge aclk);
    tx_data = 8'h3C; exp_q.push_back(8'h3C);
    @(negedge aclk);
    tx_valid = 1'b0;
    wait_start("b2b", ok);
    if (ok) begin
      capture_frame("b2b_first", got);
      capture_frame("b2b_second", got);
      total++; if (txd !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL b2b_end: txd=%b busy=%b exp txd=1 busy=0", txd, busy);
      end
    end
  endtask

  task automatic test_same_cycle;
    logic [FRAME-1:0] got;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      tx_valid = 1'b1; tx_data = b;
      if (i > 0) exp_q.push_back(b);
      @(negedge aclk);
    end
    tx_valid = 1'b0;
    repeat (FRAME - 3) @(negedge aclk);
    total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL same_pre_level: got=%0d exp=3", fifo_level); end
    b = 8'($urandom);
    tx_valid = 1'b1; tx_data = b; exp_q.push_back(b);
    @(negedge aclk);
    tx_valid = 1'b0;
    total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL same_level: got=%0d exp=3", fifo_level); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL same_ready: got=%b exp=1", tx_ready); end
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL same_start: got=%b exp=0", txd); end
    for (int i = 0; i < 4; i++) capture_frame("same_cycle", got);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_drain: got=%b exp=0", busy); end
  endtask

  task automatic test_fill;
    int pushed = 0;
    int full_seen = 0;
    fork
      begin
        int guard = 0;
        logic [7:0] cur;
        cur = 8'($urandom);
        while (pushed < 20 && guard < 5000) begin
          tx_valid = 1'b1; tx_data = cur;
          if (fifo_level == 5'd16) begin
            full_seen++;
            total++;
            if (tx_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_full: got=%b exp=0", tx_ready); end
          end
          if (tx_ready) begin
            exp_q.push_back(cur);
            pushed++;
            cur = 8'($urandom);
          end
          @(negedge aclk);
          guard++;
        end
        tx_valid = 1'b0;
      end
      begin
        logic [FRAME-1:0] got;
        bit ok;
        wait_start("fill", ok);
        if (ok) for (int i = 0; i < 20; i++) capture_frame("fill", got);
      end
    join
    total++; if (full_seen == 0) begin bad++; $display("FAIL fill_reached_full: got=0 exp>0 cycles at level 16"); end
    total++; if (pushed != 20) begin bad++; $display("FAIL fill_pushed: got=%0d exp=20", pushed); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fill_lost: got=%0d left exp=0", exp_q.size()); end
  endtask

  task automatic test_random;
    fork
      begin
        logic [7:0] cur;
        for (int i = 0; i < 8; i++) begin
          int gap;
          int guard;
          gap = $urandom_range(0, 60);
          tx_valid = 1'b0;
          repeat (gap) @(negedge aclk);
          cur = 8'($urandom);
          tx_valid = 1'b1; tx_data = cur;
          guard = 0;
          while (!tx_ready && guard < 2000) begin
            @(negedge aclk);
            guard++;
          end
          exp_q.push_back(cur);
          @(negedge aclk);
        end
        tx_valid = 1'b0;
      end
      begin
        logic [FRAME-1:0] got;
        bit ok;
        for (int i = 0; i < 8; i++) begin
          wait_start("random", ok);
          if (!ok) break;
          capture_frame("random", got);
        end
      end
    join
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL random_left: got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [FRAME-1:0] got;
    logic pb;
    bit ok;
    tx_valid = 1'b1; tx_data = 8'h07; exp_q.push_back(8'h07);
    @(negedge aclk);
    tx_valid = 1'b0;
    wait_start("par07", ok);
    if (ok) begin
      capture_frame("par07", got);
      pb = got[9*DIV + 1];
      total++; if (pb !== 1'b1) begin bad++; $display("FAIL parity_07: got=%b exp=1", pb); end
      total++; if (busy !== 1'b0 || txd !== 1'b1) begin
        bad++; $display("FAIL parity_len: busy=%b txd=%b exp 0,1 after 44 cycles", busy, txd);
      end
    end
    tx_valid = 1'b1; tx_data = 8'h03; exp_q.push_back(8'h03);
    @(negedge aclk);
    tx_valid = 1'b0;
    wait_start("par03", ok);
    if (ok) begin
      capture_frame("par03", got);
      pb = got[9*DIV + 1];
      total++; if (pb !== 1'b0) begin bad++; $display("FAIL parity_03: got=%b exp=0", pb); end
    end
  endtask
`endif

  task automatic test_reset_mid;
    int lows = 0;
    int busys = 0;
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1; tx_data = 8'($urandom);
      @(negedge aclk);
    end
    tx_valid = 1'b0;
    repeat (13) @(negedge aclk);
    total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL mid_level: got=%0d exp=5", fifo_level); end
    areset = 1'b1;
    @(negedge aclk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL mid_txd: got=%b exp=1", txd); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_flush: got=%0d exp=0", fifo_level); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got=%b exp=0", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got=%b exp=0", tx_ready); end
    areset = 1'b0;
    #1;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_release: got=%b exp=1", tx_ready); end
    repeat (3 * FRAME) begin
      @(negedge aclk);
      if (txd !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL mid_silent: got=%0d low cycles exp=0", lows); end
    total++; if (busys != 0) begin bad++; $display("FAIL mid_idle: got=%0d busy cycles exp=0", busys); end
  endtask

  initial begin
    areset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    @(negedge aclk);
    test_reset();
    test_single();
    test_back_to_back();
    test_same_cycle();
    test_fill();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
